// File: rtl/r2fft_frame_ctrl.sv
// r2fft_frame_ctrl: ping-pong, multi-channel frame controller in front of the radix-2 FFT core.
//
// Captures a channel-major sample stream into one of two frame banks in bit-reversed order,
// tracks the per-channel input bit width, starts the core once per channel on the full bank,
// and exposes the finished bank for DMA readout. Capture of the next frame overlaps compute
// and readout of the current one.
//
// Ports:
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   autorun_i, run_i, fin_i   compute start policy / manual start / readout finished
//   sact_i, sdw_real_i/imag_i input sample stream; sready_o when a bank can be filled
//   wact_o, wa_o, wdw_o       frame memory write, wa = {bank, ch, bitrev(idx)}, wdw = {imag, real}
//   core_run_o, core_base_o, core_bw_o, core_done_i, core_exp_i   FFT core handshake
//   done_o, bfpexp_o          finished bank and per-channel exponents (ch0 in the LSBs)
//   dmaact_i, dmaa_i, ract_o, ra_o   readout request / memory read
//   ovf_o, drop_cnt_o         sticky overflow flag and saturating dropped-sample count
//
// Build option: define R2FFT_FRAME_CTRL_DROPCNT_EN to implement drop_cnt_o; otherwise it is
// tied to zero (ovf_o is always implemented).
module r2fft_frame_ctrl #(
    parameter int unsigned FFT_LENGTH = 1024,
    parameter int unsigned FFT_DW     = 16,
    parameter int unsigned NUM_CH     = 4,
    localparam int unsigned FFT_N     = $clog2(FFT_LENGTH),
    localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int unsigned BW_W      = $clog2(FFT_DW) + 1,
    localparam int unsigned AW        = 1 + CH_W + FFT_N
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    autorun_i,
    input  logic                    run_i,
    input  logic                    fin_i,
    input  logic                    sact_i,
    input  logic [FFT_DW-1:0]       sdw_real_i,
    input  logic [FFT_DW-1:0]       sdw_imag_i,
    output logic                    sready_o,
    output logic                    wact_o,
    output logic [AW-1:0]           wa_o,
    output logic [2*FFT_DW-1:0]     wdw_o,
    output logic                    core_run_o,
    output logic [AW-FFT_N-1:0]     core_base_o,
    output logic [BW_W-1:0]         core_bw_o,
    input  logic                    core_done_i,
    input  logic [7:0]              core_exp_i,
    output logic                    done_o,
    output logic [8*NUM_CH-1:0]     bfpexp_o,
    input  logic                    dmaact_i,
    input  logic [CH_W+FFT_N-1:0]   dmaa_i,
    output logic                    ract_o,
    output logic [AW-1:0]           ra_o,
    output logic                    ovf_o,
    output logic [15:0]             drop_cnt_o
);

    localparam logic [FFT_N-1:0] IdxLast = FFT_N'(FFT_LENGTH - 1);
    localparam logic [CH_W-1:0]  ChLast  = CH_W'(NUM_CH - 1);

    typedef enum logic [1:0] {StIdle, StStart, StWait, StDone} state_e;

    // Significant bits of a signed value: 0 for zero, 1 for -1.
    function automatic logic [BW_W-1:0] bit_width(input logic [FFT_DW-1:0] x);
        logic [BW_W-1:0] w;
        w = (x == '0) ? '0 : BW_W'(1);
        for (int i = 0; i < FFT_DW - 1; i++) begin
            if (x[i] != x[FFT_DW-1]) w = BW_W'(i + 2);
        end
        return w;
    endfunction

    function automatic logic [FFT_N-1:0] bitrev(input logic [FFT_N-1:0] x);
        logic [FFT_N-1:0] r;
        for (int i = 0; i < FFT_N; i++) r[i] = x[FFT_N-1-i];
        return r;
    endfunction

    state_e              state_q, state_d;
    logic [1:0]          full_q, full_d;
    logic                wbank_q, wbank_d;
    logic                cbank_q, cbank_d;
    logic [FFT_N-1:0]    idx_q, idx_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [CH_W-1:0]     k_q, k_d;
    logic [BW_W-1:0]     bwreg_q [2][NUM_CH];
    logic [BW_W-1:0]     bwreg_d [2][NUM_CH];
    logic [8*NUM_CH-1:0] bfpexp_q, bfpexp_d;
    logic                ovf_q, ovf_d;

    logic                accept;
    logic                drop;
    logic                fill_done;
    logic                release_bank;
    logic [BW_W-1:0]     bw_re, bw_im, bw_smp;

    // ---------------------------------------------------------------- input side
    assign sready_o  = ~full_q[wbank_q];
    assign accept    = sact_i & sready_o;
    assign drop      = sact_i & ~sready_o;
    assign fill_done = accept && (idx_q == IdxLast) && (ch_q == ChLast);

    assign wact_o = accept;
    assign wa_o   = accept ? {wbank_q, ch_q, bitrev(idx_q)} : '0;
    assign wdw_o  = accept ? {sdw_imag_i, sdw_real_i} : '0;

    assign bw_re  = bit_width(sdw_real_i);
    assign bw_im  = bit_width(sdw_imag_i);
    assign bw_smp = (bw_re > bw_im) ? bw_re : bw_im;

    always_comb begin
        idx_d   = idx_q;
        ch_d    = ch_q;
        wbank_d = wbank_q;
        bwreg_d = bwreg_q;
        if (accept) begin
            // FFT_LENGTH is a power of two, so idx wraps on its own.
            idx_d = idx_q + 1'b1;
            if (idx_q == IdxLast) begin
                ch_d = (ch_q == ChLast) ? '0 : ch_q + 1'b1;
            end
            if (fill_done) wbank_d = ~wbank_q;
            // First sample of a channel restarts its running maximum.
            if ((idx_q == '0) || (bw_smp > bwreg_q[wbank_q][ch_q])) begin
                bwreg_d[wbank_q][ch_q] = bw_smp;
            end
        end
    end

    // Fill completion and release always target different banks, so both may apply at once.
    always_comb begin
        full_d = full_q;
        if (fill_done)    full_d[wbank_q] = 1'b1;
        if (release_bank) full_d[cbank_q] = 1'b0;
    end

    assign ovf_d = ovf_q | drop;
    assign ovf_o = ovf_q;

    // ---------------------------------------------------------------- compute FSM
    assign release_bank = (state_q == StDone) && fin_i;
    assign core_base_o  = {cbank_q, k_q};
    assign core_bw_o    = bwreg_q[cbank_q][k_q];
    assign bfpexp_o     = bfpexp_q;

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        cbank_d    = cbank_q;
        bfpexp_d   = bfpexp_q;
        core_run_o = 1'b0;
        done_o     = 1'b0;
        ract_o     = 1'b0;
        ra_o       = '0;
        unique case (state_q)
            StIdle: begin
                if (full_q[cbank_q] && (autorun_i || run_i)) state_d = StStart;
            end
            StStart: begin
                core_run_o = 1'b1;
                state_d    = StWait;
            end
            StWait: begin
                if (core_done_i) begin
                    bfpexp_d[{k_q, 3'b000} +: 8] = core_exp_i;
                    if (k_q == ChLast) begin
                        state_d = StDone;
                    end else begin
                        k_d     = k_q + 1'b1;
                        state_d = StStart;
                    end
                end
            end
            StDone: begin
                done_o = 1'b1;
                ract_o = dmaact_i;
                ra_o   = {cbank_q, dmaa_i};
                if (fin_i) begin
                    cbank_d = ~cbank_q;
                    k_d     = '0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // ---------------------------------------------------------------- state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            full_q   <= '0;
            wbank_q  <= 1'b0;
            cbank_q  <= 1'b0;
            idx_q    <= '0;
            ch_q     <= '0;
            k_q      <= '0;
            bfpexp_q <= '0;
            ovf_q    <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                for (int c = 0; c < NUM_CH; c++) bwreg_q[b][c] <= '0;
            end
        end else begin
            state_q  <= state_d;
            full_q   <= full_d;
            wbank_q  <= wbank_d;
            cbank_q  <= cbank_d;
            idx_q    <= idx_d;
            ch_q     <= ch_d;
            k_q      <= k_d;
            bfpexp_q <= bfpexp_d;
            ovf_q    <= ovf_d;
            bwreg_q  <= bwreg_d;
        end
    end

`ifdef R2FFT_FRAME_CTRL_DROPCNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) drop_cnt_q <= '0;
        else         drop_cnt_q <= drop_cnt_d;
    end

    assign drop_cnt_o = drop_cnt_q;
`else
    assign drop_cnt_o = '0;
`endif

endmodule

// File: tb/tb_r2fft_frame_ctrl.sv
// Self-checking bench for r2fft_frame_ctrl at FFT_LENGTH=8, FFT_DW=16, NUM_CH=2.
// Stimulus pushes expected writes, core starts, done events and reads into queues; a monitor
// pops and compares whenever the DUT presents the matching output.
module tb_r2fft_frame_ctrl;

    typedef struct packed { logic [4:0] wa; logic [31:0] wdw; } wr_t;
    typedef struct packed { logic [1:0] base; logic [4:0] bw; int cyc; } run_t;
    typedef struct packed { logic [15:0] exps; int cyc; } dn_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        autorun = 1'b0, run = 1'b0, fin = 1'b0, sact = 1'b0;
    logic [15:0] sdw_real = '0, sdw_imag = '0;
    logic        sready, wact, core_run, done, ract, ovf;
    logic [4:0]  wa, ra, core_bw;
    logic [31:0] wdw;
    logic [1:0]  core_base;
    logic        core_done = 1'b0;
    logic [7:0]  core_exp = '0;
    logic [15:0] bfpexp, drop_cnt;
    logic        dmaact = 1'b0;
    logic [3:0]  dmaa = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_cyc = 0;
    logic done_prev = 1'b0;

    wr_t        wq[$];
    run_t       rq[$];
    dn_t        dq[$];
    logic [4:0] aq[$];

    int brev[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    logic [15:0] a0_re[8] = '{16'h0001, 16'h0100, 16'h0010, 16'hFF00,
                              16'h0000, 16'hFFFF, 16'h007F, 16'h0003};
    logic [15:0] a0_im[8] = '{16'h0000, 16'h0001, 16'hFFF0, 16'h0080,
                              16'h0000, 16'h0002, 16'hFFFF, 16'h0004};

    r2fft_frame_ctrl #(
        .FFT_LENGTH(8),
        .FFT_DW    (16),
        .NUM_CH    (2)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .autorun_i  (autorun),
        .run_i      (run),
        .fin_i      (fin),
        .sact_i     (sact),
        .sdw_real_i (sdw_real),
        .sdw_imag_i (sdw_imag),
        .sready_o   (sready),
        .wact_o     (wact),
        .wa_o       (wa),
        .wdw_o      (wdw),
        .core_run_o (core_run),
        .core_base_o(core_base),
        .core_bw_o  (core_bw),
        .core_done_i(core_done),
        .core_exp_i (core_exp),
        .done_o     (done),
        .bfpexp_o   (bfpexp),
        .dmaact_i   (dmaact),
        .dmaa_i     (dmaa),
        .ract_o     (ract),
        .ra_o       (ra),
        .ovf_o      (ovf),
        .drop_cnt_o (drop_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One sample per cycle; the expected write is queued before it is presented.
    task automatic put(input logic b, input int c, input int i,
                       input logic [15:0] re, input logic [15:0] im);
        wr_t e;
        sact     = 1'b1;
        sdw_real = re;
        sdw_imag = im;
        e.wa     = {b, c[0], 3'(brev[i])};
        e.wdw    = {im, re};
        wq.push_back(e);
        last_cyc = cyc;
        tick();
    endtask

    task automatic exp_run(input logic [1:0] base, input logic [4:0] bw, input int at);
        run_t e;
        e.base = base;
        e.bw   = bw;
        e.cyc  = at;
        rq.push_back(e);
    endtask

    task automatic wait_run(input int lim);
        bit seen = 1'b0;
        for (int n = 0; n < lim && !seen; n++) begin
            @(negedge clk);
            seen = core_run;
        end
        chk("core_run_seen", seen, 1);
        tick();
    endtask

    task automatic wait_done(input int lim);
        bit seen = 1'b0;
        for (int n = 0; n < lim && !seen; n++) begin
            @(negedge clk);
            seen = done;
        end
        chk("done_seen", seen, 1);
        tick();
    endtask

    task automatic pulse_done(input logic [7:0] e);
        core_done = 1'b1;
        core_exp  = e;
        tick();
        core_done = 1'b0;
    endtask

    // ---------------------------------------------------------------- monitor
    always @(negedge clk) begin
        wr_t  w;
        run_t r;
        dn_t  d;
        if (!rst_n) begin
            done_prev <= 1'b0;
        end else begin
            if (wact) begin
                chk("wact_expected", wq.size() != 0, 1);
                if (wq.size() != 0) begin
                    w = wq.pop_front();
                    chk("wa", wa, w.wa);
                    chk("wdw", wdw, w.wdw);
                end
            end
            if (core_run) begin
                chk("core_run_expected", rq.size() != 0, 1);
                if (rq.size() != 0) begin
                    r = rq.pop_front();
                    chk("core_base", core_base, r.base);
                    chk("core_bw", core_bw, r.bw);
                    chk("core_run_cycle", cyc, r.cyc);
                end
            end
            if (done && !done_prev) begin
                chk("done_expected", dq.size() != 0, 1);
                if (dq.size() != 0) begin
                    d = dq.pop_front();
                    chk("bfpexp", bfpexp, d.exps);
                    chk("done_cycle", cyc, d.cyc);
                end
            end
            if (ract) begin
                chk("ract_expected", aq.size() != 0, 1);
                if (aq.size() != 0) chk("ra", ra, aq.pop_front());
            end
            done_prev <= done;
        end
    end

    // ---------------------------------------------------------------- stimulus
    initial begin
        dn_t de;
        int  cnt;

        #2;
        chk("rst_sready", sready, 1);
        chk("rst_outputs", {wact, wa, wdw, core_run, core_base, core_bw, done, ract, ra, ovf}, 0);
        chk("rst_bfpexp_drop", {bfpexp, drop_cnt}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // run with no full bank is ignored
        run = 1'b1;
        tick();
        run = 1'b0;
        cnt = 0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if (core_run) cnt++;
        end
        chk("run_ignored_empty", cnt, 0);
        tick();

        // frame A into bank 0, autorun
        autorun = 1'b1;
        for (int c = 0; c < 2; c++)
            for (int i = 0; i < 8; i++)
                put(1'b0, c, i, (c == 0) ? a0_re[i] : 16'h0, (c == 0) ? a0_im[i] : 16'h0);
        sact = 1'b0;
        exp_run(2'b00, 5'd10, last_cyc + 2);
        wait_run(8);

        tick();
        exp_run(2'b01, 5'd0, cyc + 1);
        pulse_done(8'hFD);
        wait_run(8);

        tick();
        de.exps = 16'h02FD;
        de.cyc  = cyc + 1;
        dq.push_back(de);
        pulse_done(8'h02);
        wait_done(8);

        // readout
        dmaact = 1'b1;
        dmaa   = 4'h5;
        aq.push_back(5'h05);
        tick();
        dmaa = 4'hB;
        aq.push_back(5'h0B);
        tick();
        dmaact = 1'b0;

        // frame B into bank 1 while bank 0 is still held
        chk("sready_bank1_free", sready, 1);
        for (int c = 0; c < 2; c++)
            for (int i = 0; i < 8; i++) begin
                if (c == 0) put(1'b1, c, i, 16'hFFFF, i[0] ? 16'hFFFF : 16'h0000);
                else put(1'b1, c, i, (i == 2) ? 16'h7FFF : 16'(i), (i == 6) ? 16'h8000 : 16'h0);
            end
        sact = 1'b0;
        chk("sready_both_full", sready, 0);
        chk("ovf_before_drop", ovf, 0);

        // frame 2 samples with no free bank are dropped
        for (int i = 0; i < 5; i++) begin
            sact     = 1'b1;
            sdw_real = 16'(100 + i);
            sdw_imag = 16'(i);
            tick();
        end
        sact = 1'b0;
        chk("ovf_after_drop", ovf, 1);
`ifdef R2FFT_FRAME_CTRL_DROPCNT_EN
        chk("drop_cnt", drop_cnt, 5);
`else
        chk("drop_cnt", drop_cnt, 0);
`endif

        // core_done outside the wait state is ignored
        pulse_done(8'h55);
        chk("bfpexp_hold", bfpexp, 16'h02FD);
        chk("done_hold", done, 1);

        // manual mode: release bank 0, bank 1 waits for run
        autorun = 1'b0;
        fin     = 1'b1;
        tick();
        fin = 1'b0;
        chk("sready_after_fin", sready, 1);
        chk("done_after_fin", done, 0);
        cnt = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (core_run) cnt++;
        end
        chk("manual_no_run", cnt, 0);
        tick();
        exp_run(2'b10, 5'd1, cyc + 1);
        run = 1'b1;
        tick();
        run = 1'b0;
        wait_run(8);

        // fin outside the done state is ignored
        fin = 1'b1;
        tick();
        fin = 1'b0;
        exp_run(2'b11, 5'd16, cyc + 1);
        pulse_done(8'h10);
        wait_run(8);

        // asynchronous reset while waiting on the core
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_sready", sready, 1);
        chk("midrst_outputs", {wact, wa, wdw, core_run, core_base, core_bw, done, ract, ra}, 0);
        chk("midrst_bfpexp", bfpexp, 0);
        chk("midrst_ovf_drop", {ovf, drop_cnt}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        put(1'b0, 0, 0, 16'h1234, 16'h5678);
        put(1'b0, 0, 1, 16'hABCD, 16'h0042);
        sact = 1'b0;
        repeat (3) tick();

        chk("wq_empty", wq.size(), 0);
        chk("rq_empty", rq.size(), 0);
        chk("dq_empty", dq.size(), 0);
        chk("aq_empty", aq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
